// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential ROM fetches into a small circular
// buffer and presents its head to decode; redirects flush the buffer via an epoch bit.
module fetch_unit #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] o_imem_addr,
    output logic        o_imem_stb,
    input  logic [31:0] i_imem_data,
    input  logic        i_imem_data_vld,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_instr_vld,
    input  logic        i_instr_rdy,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc
);

    localparam int unsigned PW = $clog2(BUF_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]   fetch_pc;
    logic          inflight;
    logic [31:0]   inflight_pc;
    logic          inflight_epoch;
    logic          epoch;
    logic [31:0]   buf_instr [BUF_DEPTH];
    logic [31:0]   buf_pc    [BUF_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic issue;
    logic push;
    logic pop;

    // The in-flight request reserves a slot, so a response always finds room.
    always_comb begin
        issue = !rst && !i_redirect && ((count + CW'(inflight)) < CW'(BUF_DEPTH));
        push  = !rst && !i_redirect && i_imem_data_vld && inflight
                && (inflight_epoch == epoch);
        pop   = !rst && !i_redirect && o_instr_vld && i_instr_rdy;
    end

    assign o_imem_addr = fetch_pc;
    assign o_imem_stb  = issue;
    assign o_instr_vld = (count != '0);
    assign o_instr     = buf_instr[rd_ptr];
    assign o_pc        = buf_pc[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc       <= PC_RESET;
            inflight       <= 1'b0;
            inflight_pc    <= '0;
            inflight_epoch <= 1'b0;
            epoch          <= 1'b0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
        end else if (i_redirect) begin
            fetch_pc <= {i_redirect_pc[31:2], 2'b00};
            inflight <= 1'b0;
            epoch    <= ~epoch;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc    <= fetch_pc;
                inflight_epoch <= epoch;
                fetch_pc       <= fetch_pc + 32'd4;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                buf_instr[i] <= '0;
                buf_pc[i]    <= '0;
            end
        end else if (push) begin
            buf_instr[wr_ptr] <= i_imem_data;
            buf_pc[wr_ptr]    <= inflight_pc;
        end
    end

endmodule
